// File: rtl/channel_adds_pkg.sv
// Shared defaults and types for the valid-qualified constant-increment adder channel.
package channel_adds_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_NUM_ADDS  = 2;
    localparam int unsigned DEF_ADD_CONST = 1;

    typedef logic [DEF_WIDTH-1:0] data_t;

endpackage

// File: rtl/add_const_stage.sv
// One combinational chain stage: out = in + K, wrapping modulo 2^WIDTH.
module add_const_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned K     = 1
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = in + WIDTH'(K);

endmodule

// File: rtl/channel_pipelined_adds.sv
// Valid-gated holding register fed by a chain of constant-increment adders.
module channel_pipelined_adds
    import channel_adds_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned NUM_ADDS  = DEF_NUM_ADDS,
    parameter int unsigned ADD_CONST = DEF_ADD_CONST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    logic [NUM_ADDS:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             result_q;
    logic                         result_valid_q;

    assign chain[0] = in_data;

    for (genvar i = 0; i < NUM_ADDS; i++) begin : g_stage
        add_const_stage #(
            .WIDTH (WIDTH),
            .K     (ADD_CONST)
        ) u_stage (
            .in  (chain[i]),
            .out (chain[i+1])
        );
    end

    // Case-equality keeps an unknown in_valid from loading the register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (in_valid === 1'b1) begin
            result_q       <= chain[NUM_ADDS];
            result_valid_q <= 1'b1;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_channel_pipelined_adds.sv
// Directed, table-driven bench for channel_pipelined_adds with default parameters.
module tb_channel_pipelined_adds;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] result;
    logic        result_valid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    channel_pipelined_adds #(
        .WIDTH     (16),
        .NUM_ADDS  (2),
        .ADD_CONST (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [15:0] data;
        logic [15:0] exp_result;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] exp_r, input logic exp_v);
        n_checks++;
        if (result === exp_r) n_pass++;
        else $display("FAIL %s result: got %h expected %h", name, result, exp_r);
        n_checks++;
        if (result_valid === exp_v) n_pass++;
        else $display("FAIL %s result_valid: got %b expected %b", name, result_valid, exp_v);
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"reset",          1'b0, 1'b0, 16'd0,    16'd0,    1'b0};
        vecs[1]  = '{"accept_10",      1'b1, 1'b1, 16'd10,   16'd12,   1'b1};
        vecs[2]  = '{"b2b_15",         1'b1, 1'b1, 16'd15,   16'd17,   1'b1};
        vecs[3]  = '{"hold_invalid",   1'b1, 1'b0, 16'd18,   16'd17,   1'b1};
        vecs[4]  = '{"wrap_fffe",      1'b1, 1'b1, 16'hFFFE, 16'h0000, 1'b1};
        vecs[5]  = '{"wrap_ffff",      1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b1};
        vecs[6]  = '{"rst_over_valid", 1'b0, 1'b1, 16'd100,  16'd0,    1'b0};
        vecs[7]  = '{"rst_hold",       1'b0, 1'b0, 16'd33,   16'd0,    1'b0};
        vecs[8]  = '{"idle_after_rst", 1'b1, 1'b0, 16'd55,   16'd0,    1'b0};
        vecs[9]  = '{"accept_7",       1'b1, 1'b1, 16'd7,    16'd9,    1'b1};
        vecs[10] = '{"max_no_wrap",    1'b1, 1'b1, 16'hFFFD, 16'hFFFF, 1'b1};
        vecs[11] = '{"accept_0",       1'b1, 1'b1, 16'd0,    16'd2,    1'b1};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].data);
            check(vecs[i].name, vecs[i].exp_result, vecs[i].exp_valid);
        end

        // Several idle edges in a row must keep the held sum.
        step(1'b1, 1'b1, 16'd15);
        check("seq_load_15", 16'd17, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'(16'h1234 + i));
            check("seq_idle", 16'd17, 1'b1);
        end

        // New input must not reach result before the next edge.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd500;
        #2;
        check("no_comb_path", 16'd17, 1'b1);
        @(posedge clk);
        #1;
        check("late_load_500", 16'd502, 1'b1);

        // Reset released then immediate valid word.
        step(1'b0, 1'b0, 16'd0);
        check("seq_rst", 16'd0, 1'b0);
        step(1'b1, 1'b1, 16'd7);
        check("seq_after_rst_7", 16'd9, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
